// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle N-bit adder/subtractor, D bits per clock.
// Operands are captured on accept and shifted right one D-bit slice per
// cycle through a registered carry. When the last slice is done, the
// result and the N/Z/V/C condition codes are written together. The stored
// carry flag can seed the next operation for ADC/SBC chaining.
module addsub_serial #(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  input  logic         cin_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ccn,
  output logic         ccz,
  output logic         ccv,
  output logic         ccc
);

  // Reject illegal widths at elaboration instead of building a broken datapath.
  if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
    $error("addsub_serial: need N >= 2, 1 <= D <= N and N %% D == 0 (N=%0d D=%0d)", N, D);
  end

  localparam int SLICES = N / D;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(SLICES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  opa_q, opa_d;     // operand A, shifted right by D each slice
  logic [N-1:0]  opb_q, opb_d;     // operand B (already inverted for subtract)
  logic          carry_q, carry_d; // carry into the current slice
  logic [N-1:0]  acc_q, acc_d;     // result being assembled from the top down
  logic [N-1:0]  result_q, result_d;
  logic          ccn_q, ccn_d;
  logic          ccz_q, ccz_d;
  logic          ccv_q, ccv_d;
  logic          ccc_q, ccc_d;

  logic          accept;
  logic          last_slice;
  logic          msb_carry;
  logic [D:0]    slice_sum;
  logic [N+D-1:0] acc_cat;
  logic [N+D-1:0] opa_cat;
  logic [N+D-1:0] opb_cat;
  logic [N-1:0]  acc_shift;
  logic [N-1:0]  opa_shift;
  logic [N-1:0]  opb_shift;

  assign in_ready   = (state_q == S_IDLE) && !reset;
  assign out_valid  = (state_q == S_DONE);
  assign accept     = in_valid && in_ready;
  assign last_slice = (cnt_q == LAST_SLICE);

  assign result = result_q;
  assign ccn    = ccn_q;
  assign ccz    = ccz_q;
  assign ccv    = ccv_q;
  assign ccc    = ccc_q;

  // One D-bit slice of the ripple: low slice of each operand plus carry.
  assign slice_sum = {1'b0, opa_q[D-1:0]} + {1'b0, opb_q[D-1:0]} + {{D{1'b0}}, carry_q};
  // Carry into the slice MSB recovered from sum ^ a ^ b at that bit; on the
  // final slice this is c[N-1], the carry into the word's sign bit.
  assign msb_carry = slice_sum[D-1] ^ opa_q[D-1] ^ opb_q[D-1];

  // Concatenate-then-slice keeps the shifts legal even when D == N.
  assign acc_cat   = {slice_sum[D-1:0], acc_q};
  assign opa_cat   = {{D{1'b0}}, opa_q};
  assign opb_cat   = {{D{1'b0}}, opb_q};
  assign acc_shift = acc_cat[N+D-1:D];
  assign opa_shift = opa_cat[N+D-1:D];
  assign opb_shift = opb_cat[N+D-1:D];

  // Next-state and datapath control for IDLE -> RUN -> DONE.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    ccn_d    = ccn_q;
    ccz_d    = ccz_q;
    ccv_d    = ccv_q;
    ccc_d    = ccc_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d   = x;
          opb_d   = y ^ {N{sub}};
          carry_d = cin_en ? ccc_q : sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        opa_d   = opa_shift;
        opb_d   = opb_shift;
        acc_d   = acc_shift;
        carry_d = slice_sum[D];
        cnt_d   = cnt_q + 1'b1;
        if (last_slice) begin
          state_d  = S_DONE;
          result_d = acc_shift;
          ccc_d    = slice_sum[D];
          ccv_d    = slice_sum[D] ^ msb_carry;
          ccn_d    = acc_shift[N-1];
          ccz_d    = (acc_shift == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and architecturally visible outputs, synchronously reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      ccn_q    <= 1'b0;
      ccz_q    <= 1'b0;
      ccv_q    <= 1'b0;
      ccc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ccn_q    <= ccn_d;
      ccz_q    <= ccz_d;
      ccv_q    <= ccv_d;
      ccc_q    <= ccc_d;
    end
  end

  // Working datapath registers, loaded on accept and shifted during RUN.
  always_ff @(posedge clock) begin
    // NOTE: no reset here; these are always loaded on accept before being read.
    opa_q   <= opa_d;
    opb_q   <= opb_d;
    carry_q <= carry_d;
    acc_q   <= acc_d;
    cnt_q   <= cnt_d;
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed vector table and corner
// sequences on N=16/D=4, random sweep on N=8 with D = 1, 2, 4, 8.
module tb_addsub_serial;

  typedef struct {
    logic [31:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic        ce;
    logic [15:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int sweep_turn = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sub, cin_en, out_valid, out_ready;
  logic [15:0] x, y, result;
  logic        ccn, ccz, ccv, ccc;

  addsub_serial #(.N(16), .D(4)) dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sub(sub), .cin_en(cin_en), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .ccn(ccn), .ccz(ccz),
    .ccv(ccv), .ccc(ccc)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: x + (y ^ mask) + cin, with flags from unsigned/signed arithmetic.
  function automatic exp_t ref_model(input int w, input longint a, input longint b,
                                     input bit s, input bit cin);
    exp_t   e;
    longint m, half, am, bm, full, sa, sb, ss;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    am   = a & m;
    bm   = s ? (~b & m) : (b & m);
    full = am + bm + longint'(cin);
    sa   = (am >= half) ? am - (m + 1) : am;
    sb   = (bm >= half) ? bm - (m + 1) : bm;
    ss   = sa + sb + longint'(cin);
    e.r  = 32'(full & m);
    e.c  = ((full >> w) & 1) != 0;
    e.n  = (((full & m) >> (w - 1)) & 1) != 0;
    e.z  = (full & m) == 0;
    e.v  = (ss > half - 1) || (ss < -half);
    return e;
  endfunction

  // Accept one operation, then wait (bounded) for out_valid with out_ready low.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic ce, output int lat);
    check("in_ready_before_accept", in_ready, 1);
    x = a; y = b; sub = s; cin_en = ce; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); sub = 1'($urandom); cin_en = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 64);
    check("out_valid_within_bound", out_valid, 1);
  endtask

  task automatic release16();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_low_after_handshake", out_valid, 0);
    check("in_ready_high_after_handshake", in_ready, 1);
  endtask

  task automatic check_out16(input string tag, input logic [15:0] r, input logic n,
                             input logic z, input logic v, input logic c);
    check($sformatf("%s_result", tag), result, r);
    check($sformatf("%s_ccn", tag), ccn, n);
    check($sformatf("%s_ccz", tag), ccz, z);
    check($sformatf("%s_ccv", tag), ccv, v);
    check($sformatf("%s_ccc", tag), ccc, c);
  endtask

  vec_t vecs[10];

  initial begin
    int   lat;
    int   cyc;
    bit   ref_c;
    exp_t e;
    logic [15:0] ra, rb;
    logic rs, rce;

    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{16'h0001, 16'h8000, 1'b1, 1'b0, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; sub = 1'b0; cin_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check_out16("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    // Directed table, including SBC/ADC chaining through the stored carry.
    for (int i = 0; i < 10; i++) begin
      run16(vecs[i].x, vecs[i].y, vecs[i].sub, vecs[i].ce, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check_out16($sformatf("vec%0d", i), vecs[i].r, vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].c);
      release16();
    end

    // Backpressure: DONE held three cycles, stray in_valid ignored.
    run16(16'h0100, 16'h0200, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 4);
    for (int k = 0; k < 3; k++) begin
      in_valid = (k == 1); x = 16'hAAAA; y = 16'h5555; sub = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("bp%0d_out_valid", k), out_valid, 1);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
      check_out16($sformatf("bp%0d", k), 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    release16();
    check("idle_holds_result", result, 16'h0300);
    // Back-to-back accept in the first IDLE cycle.
    run16(16'hC000, 16'h8000, 1'b0, 1'b0, lat);
    check("b2b_latency", lat, 4);
    check_out16("b2b", 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1);
    release16();

    // Reset two cycles after accept abandons the operation.
    x = 16'h1234; y = 16'h1111; sub = 1'b0; cin_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_run_result_held", result, 16'h4000);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    check_out16("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_ready_after", in_ready, 1);
    // Chained add right after reset must see ccc = 0.
    run16(16'h0001, 16'h0001, 1'b0, 1'b1, lat);
    check("post_rst_latency", lat, 4);
    check_out16("post_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    release16();

    // Random operations on the default configuration.
    ref_c = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rce = 1'($urandom);
      if (i % 7 == 0) rb = ra;
      e = ref_model(16, longint'(ra), longint'(rb), rs, rce ? ref_c : rs);
      run16(ra, rb, rs, rce, lat);
      check($sformatf("rnd16_%0d_latency", i), lat, 4);
      check_out16($sformatf("rnd16_%0d", i), e.r[15:0], e.n, e.z, e.v, e.c);
      ref_c = e.c;
      release16();
    end

    // Hand over to the N=8 sweep instances one at a time.
    sweep_turn = 1;
    cyc = 0;
    while (sweep_turn != 5 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    check("sweep_complete", sweep_turn, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // N = 8 sweep over D = 1, 2, 4, 8 with random operands and a running carry model.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int SD = 1 << gi;
    logic       sw_iv, sw_ir, sw_s, sw_ce, sw_ov;
    logic [7:0] sw_x, sw_y, sw_r;
    logic       sw_n, sw_z, sw_v, sw_c;

    addsub_serial #(.N(8), .D(SD)) u_dut (
      .clock(clk), .reset(reset), .in_valid(sw_iv), .in_ready(sw_ir),
      .x(sw_x), .y(sw_y), .sub(sw_s), .cin_en(sw_ce), .out_valid(sw_ov),
      .out_ready(1'b1), .result(sw_r), .ccn(sw_n), .ccz(sw_z),
      .ccv(sw_v), .ccc(sw_c)
    );

    initial begin
      exp_t e;
      bit   mc;
      int   lat;
      sw_iv = 1'b0; sw_x = '0; sw_y = '0; sw_s = 1'b0; sw_ce = 1'b0;
      wait (sweep_turn == gi + 1);
      @(posedge clk); #1;
      mc = 1'b0;
      for (int k = 0; k < 40; k++) begin
        sw_x = 8'($urandom); sw_y = 8'($urandom);
        sw_s = 1'($urandom); sw_ce = 1'($urandom);
        e = ref_model(8, longint'(sw_x), longint'(sw_y), sw_s, sw_ce ? mc : sw_s);
        check($sformatf("d%0d_%0d_in_ready", SD, k), sw_ir, 1);
        sw_iv = 1'b1;
        @(posedge clk); #1;
        sw_iv = 1'b0;
        lat = 0;
        do begin
          @(posedge clk); #1;
          lat++;
        end while (!sw_ov && lat < 32);
        check($sformatf("d%0d_%0d_latency", SD, k), lat, 8 / SD);
        check($sformatf("d%0d_%0d_result", SD, k), sw_r, e.r[7:0]);
        check($sformatf("d%0d_%0d_ccn", SD, k), sw_n, e.n);
        check($sformatf("d%0d_%0d_ccz", SD, k), sw_z, e.z);
        check($sformatf("d%0d_%0d_ccv", SD, k), sw_v, e.v);
        check($sformatf("d%0d_%0d_ccc", SD, k), sw_c, e.c);
        mc = e.c;
        @(posedge clk); #1;
      end
      sweep_turn = gi + 2;
    end
  end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised multi-cycle adder/subtractor that processes an N-bit operand pair D bits per clock, using a registered carry chain. It produces the same four condition codes as the 8-bit combinational add/sub stage: negative, zero, overflow and carry. It adds add-with-carry / subtract-with-borrow chaining and valid/ready handshakes on both sides. It sits between the operand-fetch stage and the writeback/flags register of the ALU datapath, where area matters more than single-cycle latency.

## Interface
- N, default 16: operand/result width; N ≥ 2.
- D, default 4: bits processed per cycle; 1 ≤ D ≤ N, N % D == 0; elaboration error otherwise.
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept; high only in IDLE and not in reset.
- x  input  N  operand A.
- y  input  N  operand B.
- sub  input  1  1 = x − y, 0 = x + y.
- cin_en  input  1  1 = carry-in taken from stored ccc (ADC/SBC); 0 = carry-in = sub.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  N  sum/difference.
- ccn, ccz, ccv, ccc  output  1 each  negative, zero, overflow, carry.

## Operation
- States: IDLE, RUN, DONE. Slice counter width ceil(log2(N/D)) or 1 bit minimum.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready, capture x, sub, and B = y XOR {N{sub}}.
  - Carry register loads cin = cin_en ? ccc : sub.
  - Clear counter; go to RUN.
- RUN:
  - Slice k (bits kD+D−1..kD) is added with the carry register each cycle.
  - The D-bit sum goes into the result shift register; carry register ← slice carry-out.
  - The last slice also records the carry into the MSB, c[N−1].
  - After slice N/D−1, go to DONE and update the output registers.
- Output register update at completion:
  - result = x + B + cin mod 2^N.
  - ccc = carry out of bit N−1. For subtraction, 1 = no borrow.
  - ccv = ccc XOR c[N−1].
  - ccn = result[N−1].
  - ccz = (result == 0). Reflects this result only, not AND-ed with prior ccz.
- DONE:
  - out_valid = 1. result and flags are held stable.
  - in_valid is ignored.
  - On out_valid & out_ready, go to IDLE.
- result and cc* registers change only at completion or reset; they hold their value in IDLE.
- Stored ccc for chaining is the ccc output register. Chaining after reset uses ccc = 0.
- With cin_en = 1 and sub = 1, the borrow semantics are x − y − (1 − ccc).

## Timing
- Reset values: result = 0, ccn = ccz = ccv = ccc = 0, out_valid = 0, state = IDLE. in_ready = 0 while reset is high and 1 in the cycle after reset deasserts.
- Accept on edge t. Slices are processed on edges t+1 … t+N/D. out_valid is high from edge t+N/D.
  - Default N = 16, D = 4: latency is 4 cycles.
  - D = N: latency is 1 cycle.
- Minimum throughput is one operation per N/D+1 cycles: DONE with out_ready = 1 returns to IDLE after one cycle.
- in_ready is combinational from state, so there is no accept in the same cycle as the output handshake.
- Back-to-back accept is legal in the first IDLE cycle after DONE.
- Reset asserted in any state (mid-RUN or DONE) takes effect at the next edge:
  - the operation is abandoned, with no partial result or flag update;
  - all outputs go to reset values.
- in_valid while not in IDLE has no effect. Operand inputs are sampled only at accept and need not be held.

## Test plan
- Add 0x7FFF + 0x0001, sub = 0, cin_en = 0 → result 0x8000, n = 1, z = 0, v = 1, c = 0. out_valid is asserted exactly 4 cycles after accept.
- Subtract 0x0005 − 0x0005 → 0x0000, z = 1, c = 1, v = 0, n = 0. Then subtract 0x0000 − 0x0001 → 0xFFFF, n = 1, c = 0, v = 0. Then subtract 0x8000 − 0x0001 → 0x7FFF, v = 1, c = 1.
- Chaining:
  - Add 0xFFFF + 0x0001 → 0x0000, c = 1.
  - Next, cin_en = 1, add 0x0000 + 0x0000 → 0x0001, c = 0.
  - Separately, from a prior c = 0, cin_en = 1 with sub 0x0003 − 0x0001 → 0x0001.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles in DONE; result, flags and out_valid stay constant, and in_ready = 0.
  - A pulse of in_valid with new operands is ignored.
  - Raise out_ready; the next cycle is IDLE with in_ready = 1.
- Reset mid-operation: assert reset 2 cycles after accepting 0x1234 + 0x1111.
  - Next edge: out_valid = 0, result = 0, all flags 0.
  - After release, 0x0001 + 0x0001 → 0x0002 with correct latency.
- Parameter sweep: N = 8 with D ∈ {1, 2, 4, 8}. Random operands, sub and cin_en against a reference model of x + (y ^ {N{sub}}) + cin. Check all four flags and latency N/D.
